// File: rtl/apb_node_timeout.sv
// APB 1-to-NB_SLAVE demultiplexer with a runtime address map, a decode-miss
// error response and a per-transfer watchdog that fails hung slaves.
module apb_node_timeout #(
    parameter int unsigned NB_SLAVE       = 11,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [APB_ADDR_WIDTH-1:0]          paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]          pwdata_i,
    input  logic                               pwrite_i,
    input  logic                               psel_i,
    input  logic                               penable_i,
    output logic [APB_DATA_WIDTH-1:0]          prdata_o,
    output logic                               pready_o,
    output logic                               pslverr_o,
    input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
    output logic                               pwrite_o,
    output logic [NB_SLAVE-1:0]                psel_o,
    output logic                               penable_o,
    input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_SLAVE-1:0]                pready_i,
    input  logic [NB_SLAVE-1:0]                pslverr_i,
    output logic                               timeout_o,
    output logic [APB_ADDR_WIDTH-1:0]          err_addr_o
);

    localparam int unsigned AW    = APB_ADDR_WIDTH;
    localparam int unsigned DW    = APB_DATA_WIDTH;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [NB_SLAVE-1:0] sel_q, sel_d;
    logic                miss_q, miss_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic [AW-1:0]       err_addr_q, err_addr_d;

    logic [NB_SLAVE-1:0] hit_1h;
    logic                found;
    logic                miss;
    logic                slv_ready;
    logic                slv_err;
    logic [DW-1:0]       slv_rdata;
    logic                expire;

    assign paddr_o    = paddr_i;
    assign pwdata_o   = pwdata_i;
    assign pwrite_o   = pwrite_i;
    assign timeout_o  = timeout_q;
    assign err_addr_o = err_addr_q;

    // Address decode; the lowest-index matching window wins on overlap.
    always_comb begin
        hit_1h = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NB_SLAVE; k++) begin
            if (!found && (paddr_i >= start_addr_i[k*AW +: AW])
                       && (paddr_i <= end_addr_i[k*AW +: AW])) begin
                hit_1h[k] = 1'b1;
                found     = 1'b1;
            end
        end
        miss = !found;
    end

    // Response mux from the slave latched at setup.
    always_comb begin
        slv_ready = |(pready_i & sel_q);
        slv_err   = |(pslverr_i & sel_q);
        slv_rdata = '0;
        for (int unsigned k = 0; k < NB_SLAVE; k++) begin
            if (sel_q[k]) begin
                slv_rdata = slv_rdata | prdata_i[k*DW +: DW];
            end
        end
    end

    // Next-state and master/slave-side outputs.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        miss_d     = miss_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        err_addr_d = err_addr_q;
        psel_o     = '0;
        penable_o  = 1'b0;
        pready_o   = 1'b0;
        pslverr_o  = 1'b0;
        prdata_o   = '0;
        expire     = 1'b0;

        case (state_q)
            IDLE: begin
                if (psel_i) begin
                    psel_o  = hit_1h;
                    sel_d   = hit_1h;
                    miss_d  = miss;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                penable_o = penable_i;
                if (!psel_i) begin
                    // Master abandoned the transfer: return quietly.
                    state_d = IDLE;
                end else begin
                    if (miss_q) begin
                        pready_o  = 1'b1;
                        pslverr_o = 1'b1;
                    end else begin
                        psel_o = sel_q;
                        expire = WDOG_EN && penable_i && !slv_ready && (cnt_q == CNT_LAST);
                        if (expire) begin
                            pready_o   = 1'b1;
                            pslverr_o  = 1'b1;
                            timeout_d  = 1'b1;
                            err_addr_d = paddr_i;
                        end else if (slv_ready) begin
                            pready_o  = 1'b1;
                            pslverr_o = slv_err;
                            prdata_o  = slv_rdata;
                        end else if (penable_i && (cnt_q != '1)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (pready_o && penable_i) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences both sides immediately, even mid-transfer.
        if (rst_i) begin
            psel_o    = '0;
            penable_o = 1'b0;
            pready_o  = 1'b0;
            pslverr_o = 1'b0;
            prdata_o  = '0;
        end
    end

    // State, latched decode, watchdog counter and error reporting registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            miss_q     <= 1'b0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            miss_q     <= miss_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_apb_node_timeout.sv
// Directed plus randomized bench for apb_node_timeout, scored against a
// transfer-level reference model (decode by map scan, completion cycle by rule).
module tb_apb_node_timeout;

    localparam int unsigned NB = 11;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned T  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic              pwrite, psel, penable;
    logic [DW-1:0]     prdata_m;
    logic              pready_m, pslverr_m;
    logic [NB*AW-1:0]  start_addr, end_addr;
    logic [AW-1:0]     paddr_s;
    logic [DW-1:0]     pwdata_s;
    logic              pwrite_s;
    logic [NB-1:0]     psel_s;
    logic              penable_s;
    logic [NB*DW-1:0]  prdata_s;
    logic [NB-1:0]     pready_s, pslverr_s;
    logic              timeout;
    logic [AW-1:0]     err_addr;

    logic [AW-1:0] map_s [NB];
    logic [AW-1:0] map_e [NB];

    int            vectors     = 0;
    int            miscompares = 0;
    bit            pend_to     = 1'b0;
    logic [AW-1:0] exp_err     = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NB; k++) begin
            start_addr[k*AW +: AW] = map_s[k];
            end_addr[k*AW +: AW]   = map_e[k];
        end
    end

    apb_node_timeout #(
        .NB_SLAVE(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
        .psel_i(psel), .penable_i(penable),
        .prdata_o(prdata_m), .pready_o(pready_m), .pslverr_o(pslverr_m),
        .start_addr_i(start_addr), .end_addr_i(end_addr),
        .paddr_o(paddr_s), .pwdata_o(pwdata_s), .pwrite_o(pwrite_s),
        .psel_o(psel_s), .penable_o(penable_s),
        .prdata_i(prdata_s), .pready_i(pready_s), .pslverr_i(pslverr_s),
        .timeout_o(timeout), .err_addr_o(err_addr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int k = 0; k < NB; k++) begin
            if (a >= map_s[k] && a <= map_e[k]) return k;
        end
        return -1;
    endfunction

    task automatic default_map();
        for (int k = 0; k < NB; k++) begin
            map_s[k] = 32'h1A10_0000 + 32'(k) * 32'h1000;
            map_e[k] = map_s[k] + 32'h0FFF;
        end
    endtask

    // Unselected slaves babble random responses; the selected one is scripted.
    task automatic drive_slaves(input int idx, input bit rdy, input bit err, input logic [DW-1:0] d);
        for (int k = 0; k < NB; k++) begin
            pready_s[k]            = 1'($urandom);
            pslverr_s[k]           = 1'($urandom);
            prdata_s[k*DW +: DW]   = $urandom;
        end
        if (idx >= 0) begin
            pready_s[idx]          = rdy;
            pslverr_s[idx]         = err;
            prdata_s[idx*DW +: DW] = d;
        end
    endtask

    task automatic cycle_regs();
        check("timeout_pulse", 64'(timeout), 64'(pend_to));
        check("err_addr", 64'(err_addr), 64'(exp_err));
        pend_to = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0, '0);
        #1;
        cycle_regs();
        check("idle_psel", 64'(psel_s), 64'(0));
        check("idle_pready", 64'(pready_m), 64'(0));
        check("idle_pslverr", 64'(pslverr_m), 64'(0));
        check("idle_prdata", 64'(prdata_m), 64'(0));
    endtask

    // One complete transfer; the model decides which slave, when it ends and how.
    task automatic xfer(input logic [AW-1:0] a, input bit wr, input int waits,
                        input bit serr, input logic [DW-1:0] rd, input bit gap_after);
        int            idx, last;
        bit            timed, err_end;
        logic [NB-1:0] oh;
        logic [DW-1:0] wd;
        idx     = ref_decode(a);
        oh      = (idx >= 0) ? (NB'(1) << idx) : '0;
        timed   = (idx >= 0) && (waits >= int'(T));
        last    = (idx < 0) ? 1 : (timed ? int'(T) : waits + 1);
        err_end = (idx < 0) || timed || serr;
        wd      = $urandom;

        @(negedge clk);
        paddr = a; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
        drive_slaves(idx, 1'b0, 1'b0, rd);
        #1;
        cycle_regs();
        check("setup_psel", 64'(psel_s), 64'(oh));
        check("setup_penable", 64'(penable_s), 64'(0));
        check("setup_pready", 64'(pready_m), 64'(0));
        check("pass_paddr", 64'(paddr_s), 64'(a));
        check("pass_pwdata", 64'(pwdata_s), 64'(wd));
        check("pass_pwrite", 64'(pwrite_s), 64'(wr));

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            penable = 1'b1;
            drive_slaves(idx, (c == waits + 1), serr, rd);
            #1;
            cycle_regs();
            check("acc_psel", 64'(psel_s), 64'(oh));
            check("acc_penable", 64'(penable_s), 64'(1));
            if (c == last) begin
                check("end_pready", 64'(pready_m), 64'(1));
                check("end_pslverr", 64'(pslverr_m), 64'(err_end));
                check("end_prdata", 64'(prdata_m), ((idx < 0) || timed) ? 64'(0) : 64'(rd));
            end else begin
                check("wait_pready", 64'(pready_m), 64'(0));
                check("wait_pslverr", 64'(pslverr_m), 64'(0));
                check("wait_prdata", 64'(prdata_m), 64'(0));
            end
        end
        pend_to = timed;
        if (timed) exp_err = a;
        if (gap_after) idle_cycle();
    endtask

    initial begin
        logic [AW-1:0] a;
        int            k;

        default_map();
        rst = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0, '0);

        // Reset state
        @(negedge clk); #1;
        check("rst_psel", 64'(psel_s), 64'(0));
        check("rst_pready", 64'(pready_m), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        check("rst_err_addr", 64'(err_addr), 64'(0));
        @(negedge clk); rst = 1'b0;
        idle_cycle();

        // Mapped read, zero wait states
        xfer(32'h1A10_3004, 1'b0, 0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        // Unmapped write
        xfer(32'h2000_0000, 1'b1, 0, 1'b0, 32'h0, 1'b1);
        // Hung slave 5: watchdog fires, pulse lasts one cycle
        xfer(32'h1A10_5010, 1'b0, 100, 1'b0, 32'h1234_5678, 1'b1);
        idle_cycle();
        // Three wait states complete normally, then back-to-back to slave 1
        xfer(32'h1A10_0040, 1'b0, 3, 1'b0, 32'hCAFE_0000, 1'b0);
        xfer(32'h1A10_1000, 1'b1, 0, 1'b1, 32'h0000_F00D, 1'b1);
        // Overlapping windows: slave 2 outranks slave 7
        map_s[7] = 32'h1A10_2000; map_e[7] = 32'h1A10_7FFF;
        xfer(32'h1A10_2000, 1'b0, 1, 1'b0, 32'hA5A5_5A5A, 1'b1);
        default_map();

        // Reset during the second wait cycle
        @(negedge clk);
        paddr = 32'h1A10_4008; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        drive_slaves(4, 1'b0, 1'b0, 32'h0);
        @(negedge clk); penable = 1'b1; drive_slaves(4, 1'b0, 1'b0, 32'h0);
        @(negedge clk); drive_slaves(4, 1'b0, 1'b0, 32'h0); rst = 1'b1;
        #1;
        exp_err = '0; pend_to = 1'b0;
        check("midrst_psel", 64'(psel_s), 64'(0));
        check("midrst_penable", 64'(penable_s), 64'(0));
        check("midrst_pready", 64'(pready_m), 64'(0));
        cycle_regs();
        @(negedge clk); rst = 1'b0;
        idle_cycle();
        xfer(32'h1A10_4008, 1'b0, 1, 1'b0, 32'h7777_1111, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h3000_0000 | 32'($urandom_range(0, 32'hFFFF));
            end else begin
                k = int'($urandom_range(0, NB - 1));
                a = map_s[k] + 32'($urandom_range(0, 32'hFFF));
            end
            xfer(a, 1'($urandom), int'($urandom_range(0, 5)), 1'($urandom),
                 $urandom, 1'($urandom));
        end
        idle_cycle();
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
